// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit header layout, type codes and route bit positions.
// Field offsets are counted down from the flit MSB so they hold for any flit width.
package noc_pkg;

    localparam int unsigned FLIT_SIZE  = 256;
    localparam int unsigned HEADER_LEN = 3;
    localparam int unsigned ROUTE_LEN  = 7;
    localparam int unsigned VC_W       = 2;

    typedef enum logic [2:0] {
        FLIT_HEAD      = 3'b001,
        FLIT_BODY      = 3'b010,
        FLIT_TAIL      = 3'b011,
        FLIT_HEAD_TAIL = 3'b100,
        CREDIT_FLIT    = 3'b111
    } flit_type_e;

    localparam int unsigned DIR_XPOS  = 0;
    localparam int unsigned DIR_YPOS  = 1;
    localparam int unsigned DIR_ZPOS  = 2;
    localparam int unsigned DIR_XNEG  = 3;
    localparam int unsigned DIR_YNEG  = 4;
    localparam int unsigned DIR_ZNEG  = 5;
    localparam int unsigned DIR_EJECT = 6;

    // Bit distance from the flit MSB to the first bit of each header field.
    localparam int unsigned TYPE_OFF = 0;
    localparam int unsigned VC_OFF   = HEADER_LEN;
    localparam int unsigned DST_OFF  = HEADER_LEN + VC_W;

    typedef enum logic [0:0] {
        StIdle,
        StInPkt
    } pkt_state_e;

endpackage

// File: rtl/torus_dim_route.sv
// Shortest-path direction for one torus dimension; ties (delta == DIM/2) go positive.
module torus_dim_route
    import noc_pkg::*;
#(
    parameter int unsigned CUR     = 0,
    parameter int unsigned DIM     = 4,
    parameter int unsigned COORD_W = 4
) (
    input  logic [COORD_W-1:0] dst,
    output logic               pos,
    output logic               neg,
    output logic               done
);

    logic [31:0] delta;

    // Adding DIM before subtracting keeps the modular difference non-negative.
    assign delta = (32'(dst) + DIM - (CUR % DIM)) % DIM;

    assign done = (delta == 32'd0);
    assign pos  = !done && (delta <= DIM / 2);
    assign neg  = (delta > DIM / 2);

endmodule

// File: rtl/route_comp_pipe.sv
// Registered route-computation stage for one 3D-torus input port with a one-entry skid.
// Optional dateline VC rewrite is enabled by defining ROUTE_DATELINE_EN.
module route_comp_pipe
    import noc_pkg::*;
#(
    parameter int unsigned CUR_X     = 0,
    parameter int unsigned CUR_Y     = 0,
    parameter int unsigned CUR_Z     = 0,
    parameter int unsigned DIM_X     = 4,
    parameter int unsigned DIM_Y     = 4,
    parameter int unsigned DIM_Z     = 4,
    parameter int unsigned COORD_W   = 4,
    parameter int unsigned FLIT_SIZE = 256
`ifdef ROUTE_DATELINE_EN
    ,
    // Dimension of the link feeding this port (0=X, 1=Y, 2=Z, 3=injection).
    parameter int unsigned IN_DIM    = 3
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] flit_in,
    input  logic                 flit_valid_in,
    output logic                 ready_out,
    input  logic                 stall_in,
    output logic [FLIT_SIZE-1:0] flit_out,
    output logic                 flit_valid_out,
    output logic [ROUTE_LEN-1:0] route_out,
    output logic                 credit_valid_out,
    output logic [VC_W-1:0]      credit_vc_out,
    output logic                 err_protocol
);

    localparam int unsigned TYPE_MSB = FLIT_SIZE - 1 - TYPE_OFF;
    localparam int unsigned VC_MSB   = FLIT_SIZE - 1 - VC_OFF;
    localparam int unsigned DX_MSB   = FLIT_SIZE - 1 - DST_OFF;
    localparam int unsigned DY_MSB   = DX_MSB - COORD_W;
    localparam int unsigned DZ_MSB   = DY_MSB - COORD_W;

    logic [HEADER_LEN-1:0] in_type;
    logic [VC_W-1:0]       in_vc;
    logic                  is_credit, is_head, is_cont, data_req, bad_type, accept;
    logic                  x_pos, x_neg, x_done;
    logic                  y_pos, y_neg, y_done;
    logic                  z_pos, z_neg, z_done;
    logic [ROUTE_LEN-1:0]  comp_route, new_route, held_route_q;
    logic [FLIT_SIZE-1:0]  new_flit;
    logic                  take, use_held, set_err, latch_held;
    pkt_state_e            state_q, state_d;

    logic                  out_valid_q, skid_valid_q, credit_valid_q, err_q;
    logic [FLIT_SIZE-1:0]  out_flit_q, skid_flit_q;
    logic [ROUTE_LEN-1:0]  out_route_q, skid_route_q;
    logic [VC_W-1:0]       credit_vc_q;
    logic                  advance;

    assign in_type = flit_in[TYPE_MSB -: HEADER_LEN];
    assign in_vc   = flit_in[VC_MSB -: VC_W];

    assign is_head   = (in_type == FLIT_HEAD) || (in_type == FLIT_HEAD_TAIL);
    assign is_cont   = (in_type == FLIT_BODY) || (in_type == FLIT_TAIL);
    assign is_credit = flit_valid_in && (in_type == CREDIT_FLIT);
    assign data_req  = flit_valid_in && (is_head || is_cont);
    assign bad_type  = flit_valid_in && !is_credit && !is_head && !is_cont;
    assign accept    = data_req && ready_out;

    torus_dim_route #(.CUR(CUR_X), .DIM(DIM_X), .COORD_W(COORD_W)) u_dim_x (
        .dst  (flit_in[DX_MSB -: COORD_W]),
        .pos  (x_pos),
        .neg  (x_neg),
        .done (x_done)
    );

    torus_dim_route #(.CUR(CUR_Y), .DIM(DIM_Y), .COORD_W(COORD_W)) u_dim_y (
        .dst  (flit_in[DY_MSB -: COORD_W]),
        .pos  (y_pos),
        .neg  (y_neg),
        .done (y_done)
    );

    torus_dim_route #(.CUR(CUR_Z), .DIM(DIM_Z), .COORD_W(COORD_W)) u_dim_z (
        .dst  (flit_in[DZ_MSB -: COORD_W]),
        .pos  (z_pos),
        .neg  (z_neg),
        .done (z_done)
    );

    // Dimension order: the first unresolved dimension picks the port.
    always_comb begin
        comp_route = '0;
        if (!x_done) begin
            comp_route[DIR_XPOS] = x_pos;
            comp_route[DIR_XNEG] = x_neg;
        end else if (!y_done) begin
            comp_route[DIR_YPOS] = y_pos;
            comp_route[DIR_YNEG] = y_neg;
        end else if (!z_done) begin
            comp_route[DIR_ZPOS] = z_pos;
            comp_route[DIR_ZNEG] = z_neg;
        end else begin
            comp_route[DIR_EJECT] = 1'b1;
        end
    end

    // Packet FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            held_route_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_held) held_route_q <= comp_route;
        end
    end

    // Packet FSM: next state. Only accepted flits move it.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                StIdle:  if (in_type == FLIT_HEAD) state_d = StInPkt;
                StInPkt: begin
                    if (in_type == FLIT_TAIL || in_type == FLIT_HEAD_TAIL) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Packet FSM: outputs.
    always_comb begin
        take       = 1'b0;
        use_held   = 1'b0;
        latch_held = 1'b0;
        set_err    = bad_type || (data_req && !ready_out);
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (is_head) begin
                        take       = 1'b1;
                        latch_held = (in_type == FLIT_HEAD);
                    end else begin
                        set_err = 1'b1;
                    end
                end
                StInPkt: begin
                    take = 1'b1;
                    if (is_head) begin
                        set_err    = 1'b1;
                        latch_held = (in_type == FLIT_HEAD);
                    end else begin
                        use_held = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign new_route = use_held ? held_route_q : comp_route;

`ifdef ROUTE_DATELINE_EN
    localparam int unsigned VC_LSB = VC_MSB - VC_W + 1;

    logic       wrap, turn, head_vc0, vc0_new, held_vc0_q;
    logic [1:0] route_dim;

    assign route_dim = !x_done ? 2'd0 : !y_done ? 2'd1 : !z_done ? 2'd2 : 2'd3;

    assign wrap = (comp_route[DIR_XPOS] && (CUR_X == DIM_X - 1)) ||
                  (comp_route[DIR_XNEG] && (CUR_X == 0)) ||
                  (comp_route[DIR_YPOS] && (CUR_Y == DIM_Y - 1)) ||
                  (comp_route[DIR_YNEG] && (CUR_Y == 0)) ||
                  (comp_route[DIR_ZPOS] && (CUR_Z == DIM_Z - 1)) ||
                  (comp_route[DIR_ZNEG] && (CUR_Z == 0));
    assign turn     = !comp_route[DIR_EJECT] && (32'(route_dim) != IN_DIM);
    assign head_vc0 = wrap ? 1'b1 : (turn ? 1'b0 : in_vc[0]);
    assign vc0_new  = use_held ? held_vc0_q : head_vc0;

    always_ff @(posedge clk) begin
        if (rst) held_vc0_q <= 1'b0;
        else if (latch_held) held_vc0_q <= head_vc0;
    end

    always_comb begin
        new_flit         = flit_in;
        new_flit[VC_LSB] = vc0_new;
    end
`else
    assign new_flit = flit_in;
`endif

    assign advance = !out_valid_q || !stall_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_flit_q     <= '0;
            out_route_q    <= '0;
            skid_valid_q   <= 1'b0;
            skid_flit_q    <= '0;
            skid_route_q   <= '0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            err_q          <= 1'b0;
        end else begin
            credit_valid_q <= is_credit;
            if (is_credit) credit_vc_q <= in_vc;
            if (set_err) err_q <= 1'b1;

            if (advance) begin
                // A full skid blocks input, so skid drain and take never coincide.
                out_valid_q <= skid_valid_q || take;
                if (skid_valid_q) begin
                    out_flit_q   <= skid_flit_q;
                    out_route_q  <= skid_route_q;
                    skid_valid_q <= 1'b0;
                end else if (take) begin
                    out_flit_q  <= new_flit;
                    out_route_q <= new_route;
                end
            end else if (take) begin
                skid_valid_q <= 1'b1;
                skid_flit_q  <= new_flit;
                skid_route_q <= new_route;
            end
        end
    end

    assign ready_out        = !skid_valid_q;
    assign flit_out         = out_flit_q;
    assign flit_valid_out   = out_valid_q;
    assign route_out        = out_route_q;
    assign credit_valid_out = credit_valid_q;
    assign credit_vc_out    = credit_vc_q;
    assign err_protocol     = err_q;

endmodule

// File: tb/tb_route_comp_pipe.sv
// Self-checking bench for route_comp_pipe at node (0,0,0) of a 4x4x4 torus.
module tb_route_comp_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] flit_in;
    logic         flit_valid_in;
    logic         ready_out;
    logic         stall_in;
    logic [255:0] flit_out;
    logic         flit_valid_out;
    logic [6:0]   route_out;
    logic         credit_valid_out;
    logic [1:0]   credit_vc_out;
    logic         err_protocol;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] T_HEAD = 3'b001, T_BODY = 3'b010, T_TAIL = 3'b011;
    localparam logic [2:0] T_HT = 3'b100, T_CRED = 3'b111;

    route_comp_pipe dut (
        .clk              (clk),
        .rst              (rst),
        .flit_in          (flit_in),
        .flit_valid_in    (flit_valid_in),
        .ready_out        (ready_out),
        .stall_in         (stall_in),
        .flit_out         (flit_out),
        .flit_valid_out   (flit_valid_out),
        .route_out        (route_out),
        .credit_valid_out (credit_valid_out),
        .credit_vc_out    (credit_vc_out),
        .err_protocol     (err_protocol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk(input logic [2:0] t, input logic [1:0] vc,
                                        input int x, input int y, input int z);
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
        f[255 -: 3] = t;
        f[252 -: 2] = vc;
        f[250 -: 4] = 4'(x);
        f[246 -: 4] = 4'(y);
        f[242 -: 4] = 4'(z);
        return f;
    endfunction

    // Reference: per dimension compare forward and backward hop counts around the ring.
    function automatic logic [6:0] ref_route(input int x, input int y, input int z);
        int dst[3];
        int fwd;
        logic [6:0] r;
        dst[0] = x; dst[1] = y; dst[2] = z;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            fwd = (dst[i] - 0 + 4) % 4;
            if (fwd != 0) begin
                if (fwd <= 4 - fwd) r[i] = 1'b1;
                else r[i+3] = 1'b1;
                return r;
            end
        end
        r[6] = 1'b1;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; flit_valid_in = 1'b0; stall_in = 1'b0; flit_in = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int         x, y, z;
        logic [6:0] route;
    } vec_t;

    vec_t         tbl[7];
    logic [255:0] f, fa, fb;
    logic [255:0] qf[$];
    logic [6:0]   qr[$];
    logic [6:0]   held, er;
    bit           in_pkt, cred_prev;
    logic [1:0]   cred_vc_prev;
    int           r;

    initial begin
        tbl[0] = '{1, 0, 0, 7'b0000001};  // XPOS
        tbl[1] = '{3, 0, 0, 7'b0001000};  // XNEG
        tbl[2] = '{2, 0, 0, 7'b0000001};  // tie -> XPOS
        tbl[3] = '{0, 0, 0, 7'b1000000};  // EJECT
        tbl[4] = '{0, 3, 0, 7'b0010000};  // YNEG
        tbl[5] = '{0, 0, 2, 7'b0000100};  // tie -> ZPOS
        tbl[6] = '{2, 3, 1, 7'b0000001};  // X first

        do_reset();
        chk("reset_valid", 256'(flit_valid_out), 256'd0);
        chk("reset_flit", flit_out, 256'd0);
        chk("reset_route", 256'(route_out), 256'd0);
        chk("reset_credit", 256'(credit_valid_out), 256'd0);
        chk("reset_credit_vc", 256'(credit_vc_out), 256'd0);
        chk("reset_err", 256'(err_protocol), 256'd0);
        chk("reset_ready", 256'(ready_out), 256'd1);

        // Single-flit packets, back to back, one-cycle latency.
        for (int i = 0; i < 7; i++) begin
            f = mk(T_HT, 2'(i), tbl[i].x, tbl[i].y, tbl[i].z);
            flit_in = f; flit_valid_in = 1'b1;
            tick();
            chk($sformatf("ht_valid_%0d", i), 256'(flit_valid_out), 256'd1);
            chk($sformatf("ht_route_%0d", i), 256'(route_out), 256'(tbl[i].route));
            chk($sformatf("ht_flit_%0d", i), flit_out, f);
        end
        flit_valid_in = 1'b0;
        tick();
        chk("idle_valid", 256'(flit_valid_out), 256'd0);

        // Wormhole packet: all flits follow the head's route.
        for (int i = 0; i < 5; i++) begin
            f = (i == 0) ? mk(T_HEAD, 2'd1, 0, 2, 1) :
                (i == 4) ? mk(T_TAIL, 2'd1, 3, 3, 3) : mk(T_BODY, 2'd1, 1, 0, 0);
            flit_in = f; flit_valid_in = 1'b1;
            tick();
            chk($sformatf("pkt_route_%0d", i), 256'(route_out), 256'b0000010);
            chk($sformatf("pkt_flit_%0d", i), flit_out, f);
        end
        // A HEAD_TAIL right after the TAIL is only legal if the FSM is back in IDLE.
        flit_in = mk(T_HT, 2'd0, 0, 0, 0);
        tick();
        chk("after_tail_route", 256'(route_out), 256'b1000000);
        chk("after_tail_err", 256'(err_protocol), 256'd0);
        flit_valid_in = 1'b0;
        tick();

        // Stall with skid, plus a credit while stalled.
        fa = mk(T_HT, 2'd0, 1, 0, 0);
        fb = mk(T_HT, 2'd0, 3, 0, 0);
        flit_in = fa; flit_valid_in = 1'b1;
        tick();
        flit_in = fb; stall_in = 1'b1;
        tick();
        chk("skid_ready", 256'(ready_out), 256'd0);
        chk("skid_hold_flit", flit_out, fa);
        flit_in = mk(T_CRED, 2'd2, 0, 0, 0);
        tick();
        chk("credit_valid", 256'(credit_valid_out), 256'd1);
        chk("credit_vc", 256'(credit_vc_out), 256'd2);
        chk("credit_data_valid", 256'(flit_valid_out), 256'd1);
        chk("credit_data_flit", flit_out, fa);
        flit_valid_in = 1'b0;
        tick();
        chk("credit_pulse_end", 256'(credit_valid_out), 256'd0);
        tick();
        stall_in = 1'b0;
        tick();
        chk("release_flit", flit_out, fb);
        chk("release_route", 256'(route_out), 256'b0001000);
        chk("release_valid", 256'(flit_valid_out), 256'd1);
        chk("release_ready", 256'(ready_out), 256'd1);
        tick();
        chk("release_drained", 256'(flit_valid_out), 256'd0);

        // BODY in IDLE is dropped and the error is sticky.
        flit_in = mk(T_BODY, 2'd0, 1, 0, 0); flit_valid_in = 1'b1;
        tick();
        flit_valid_in = 1'b0;
        chk("body_idle_err", 256'(err_protocol), 256'd1);
        chk("body_idle_drop", 256'(flit_valid_out), 256'd0);
        tick();
        tick();
        chk("err_sticky", 256'(err_protocol), 256'd1);

        // Reset in the middle of a packet with a flit sitting in the skid.
        flit_in = mk(T_HEAD, 2'd0, 1, 0, 0); flit_valid_in = 1'b1;
        tick();
        flit_in = mk(T_BODY, 2'd0, 0, 0, 0); stall_in = 1'b1;
        tick();
        rst = 1'b1; flit_valid_in = 1'b0; stall_in = 1'b0;
        tick();
        chk("midrst_valid", 256'(flit_valid_out), 256'd0);
        chk("midrst_flit", flit_out, 256'd0);
        chk("midrst_route", 256'(route_out), 256'd0);
        chk("midrst_err", 256'(err_protocol), 256'd0);
        chk("midrst_ready", 256'(ready_out), 256'd1);
        rst = 1'b0;
        tick();
        chk("postrst_no_emit", 256'(flit_valid_out), 256'd0);
        flit_in = mk(T_BODY, 2'd0, 0, 0, 0); flit_valid_in = 1'b1;
        tick();
        flit_valid_in = 1'b0;
        chk("postrst_idle_err", 256'(err_protocol), 256'd1);

        // Randomised traffic against a queue-based reference.
        do_reset();
        in_pkt = 1'b0; held = '0; cred_prev = 1'b0; cred_vc_prev = '0;
        for (int n = 0; n < 3000; n++) begin
            chk("rnd_credit_valid", 256'(credit_valid_out), 256'(cred_prev));
            if (cred_prev) chk("rnd_credit_vc", 256'(credit_vc_out), 256'(cred_vc_prev));
            stall_in = ($urandom_range(0, 3) == 0);
            if (flit_valid_out && !stall_in) begin
                if (qf.size() == 0) begin
                    chk("rnd_unexpected_flit", 256'(flit_valid_out), 256'd0);
                end else begin
                    chk("rnd_flit", flit_out, qf.pop_front());
                    chk("rnd_route", 256'(route_out), 256'(qr.pop_front()));
                end
            end
            cred_prev = 1'b0;
            flit_valid_in = 1'b0;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                cred_vc_prev = 2'($urandom);
                flit_in = mk(T_CRED, cred_vc_prev, 0, 0, 0);
                flit_valid_in = 1'b1;
                cred_prev = 1'b1;
            end else if (r < 7 && ready_out) begin
                if (!in_pkt) begin
                    f = mk($urandom_range(0, 1) ? T_HEAD : T_HT, 2'($urandom),
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                    er = ref_route(int'(f[250 -: 4]), int'(f[246 -: 4]), int'(f[242 -: 4]));
                    if (f[255 -: 3] == T_HEAD) begin
                        in_pkt = 1'b1;
                        held = er;
                    end
                end else begin
                    f = mk(($urandom_range(0, 2) == 0) ? T_TAIL : T_BODY, 2'($urandom),
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                    er = held;
                    if (f[255 -: 3] == T_TAIL) in_pkt = 1'b0;
                end
                flit_in = f; flit_valid_in = 1'b1;
                qf.push_back(f);
                qr.push_back(er);
            end
            tick();
        end
        flit_valid_in = 1'b0; stall_in = 1'b0;
        for (int n = 0; n < 10 && qf.size() > 0; n++) begin
            if (flit_valid_out) begin
                chk("drain_flit", flit_out, qf.pop_front());
                chk("drain_route", 256'(route_out), 256'(qr.pop_front()));
            end
            tick();
        end
        chk("rnd_all_delivered", 256'(qf.size()), 256'd0);
        chk("rnd_no_err", 256'(err_protocol), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
